// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the multi-cycle ALU (alu_mc).
//   alu_op_e    - 3-bit opcode carried on Cntr
//   alu_state_e - controller states
//   FLAG_*      - bit positions of N/Z/C/V inside ALUFlags
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_NOT  = 3'b100,
    OP_PASS = 3'b101,
    OP_MUL  = 3'b110,
    OP_CMP  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result handshake bundle for alu_mc.
//   Request side : in_valid, in_ready, A, B, Cntr
//   Result side  : out_valid, out_ready, R, ALUFlags ({N,Z,C,V}), err
// Modports: master = operand/control source and result consumer,
//           slave  = the ALU.
interface alu_mc_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Cntr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic [3:0]       ALUFlags;
  logic             err;

  modport master (
    output in_valid, A, B, Cntr, out_ready,
    input  in_ready, out_valid, R, ALUFlags, err
  );

  modport slave (
    input  in_valid, A, B, Cntr, out_ready,
    output in_ready, out_valid, R, ALUFlags, err
  );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one multiplier bit
// per cycle, WIDTH iterations after start.
// Ports:
//   clk, rst_n  - clock, async active-low reset (aborts a running multiply)
//   start       - load a (multiplicand) and b (multiplier), begin iterating
//   a, b        - WIDTH-bit operands
//   done        - high during the last iteration cycle
//   product     - 2*WIDTH-bit result of the current iteration; it is the
//                 final product while done is high, so the caller captures it
//                 on the same edge that performs the last step.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] step;

  // Upper half accumulates, lower half holds the not-yet-used multiplier bits.
  always_comb begin
    addend    = prod_q[0] ? mcand_q : '0;
    upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    step      = {upper_sum, prod_q[WIDTH-1:1]};
  end

  assign done    = busy_q && (cnt_q == CNT_LAST);
  assign product = step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= a;
      prod_q  <= {{WIDTH{1'b0}}, b};
      cnt_q   <= CNT_LOAD;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      prod_q <= step;
      cnt_q  <= cnt_q - CNT_LAST;
      if (cnt_q == CNT_LAST) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with valid/ready request and result.
// Ports:
//   clk    - clock
//   rst_n  - async active-low reset; discards any operation in flight
//   bus    - alu_mc_if.slave (A, B, Cntr in; R, ALUFlags, err out)
// Build option: ALU_MUL_EN enables opcode 110 (iterative MUL, WIDTH cycles).
// Without it the multiplier is absent and opcode 110 completes in one cycle
// with err=1 and R/ALUFlags left untouched.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request, in_ready=1
// MUL     | multiplier iterating, in_ready=0
// HOLD    | result presented with out_valid=1, in_ready follows out_ready
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  alu_state_e       state;
  logic [WIDTH-1:0] r_q;
  logic [3:0]       flags_q;
  logic             err_q;
  logic             out_valid_q;

  alu_op_e          op;
  logic             accept;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   sub_x;
  logic [WIDTH-1:0] nxt_r;
  logic [WIDTH-1:0] f_src;
  logic [3:0]       nxt_f;
  logic             nxt_err;
  logic             c_b;
  logic             v_b;
  logic             upd_f;
  logic             op_mul;

  assign op     = alu_op_e'(bus.Cntr);
  assign accept = bus.in_valid && bus.in_ready;
  assign add_x  = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_x  = {1'b0, bus.A} - {1'b0, bus.B};

  // Outcome of a single-cycle op; CMP takes N/Z from A-B while R is kept.
  always_comb begin
    nxt_r   = r_q;
    f_src   = r_q;
    nxt_f   = flags_q;
    nxt_err = 1'b0;
    c_b     = 1'b0;
    v_b     = 1'b0;
    upd_f   = 1'b1;
    op_mul  = 1'b0;
    case (op)
      OP_ADD: begin
        nxt_r = add_x[WIDTH-1:0];
        f_src = add_x[WIDTH-1:0];
        c_b   = add_x[WIDTH];
        v_b   = (bus.A[MSB] == bus.B[MSB]) && (add_x[MSB] != bus.A[MSB]);
      end
      OP_SUB, OP_CMP: begin
        if (op == OP_SUB) nxt_r = sub_x[WIDTH-1:0];
        f_src = sub_x[WIDTH-1:0];
        c_b   = ~sub_x[WIDTH];
        v_b   = (bus.A[MSB] != bus.B[MSB]) && (sub_x[MSB] != bus.A[MSB]);
      end
      OP_AND: begin
        nxt_r = bus.A & bus.B;
        f_src = nxt_r;
      end
      OP_OR: begin
        nxt_r = bus.A | bus.B;
        f_src = nxt_r;
      end
      OP_NOT: begin
        nxt_r = ~bus.B;
        f_src = nxt_r;
      end
      OP_PASS: begin
        nxt_r = bus.B;
        f_src = nxt_r;
      end
      OP_MUL: begin
        upd_f = 1'b0;
`ifdef ALU_MUL_EN
        op_mul = 1'b1;
`else
        nxt_err = 1'b1;
`endif
      end
      default: upd_f = 1'b0;
    endcase
    if (upd_f) begin
      nxt_f[FLAG_N] = f_src[MSB];
      nxt_f[FLAG_Z] = (f_src == '0);
      nxt_f[FLAG_C] = c_b;
      nxt_f[FLAG_V] = v_b;
    end
  end

`ifdef ALU_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && op_mul),
    .a       (bus.A),
    .b       (bus.B),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      r_q         <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          // In HOLD, accept implies out_ready, so the held result is consumed.
          if (accept) begin
            if (op_mul) begin
              state       <= ST_MUL;
              out_valid_q <= 1'b0;
            end else begin
              r_q         <= nxt_r;
              flags_q     <= nxt_f;
              err_q       <= nxt_err;
              state       <= ST_HOLD;
              out_valid_q <= 1'b1;
            end
          end else if (state == ST_HOLD && bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
`ifdef ALU_MUL_EN
          if (mul_done) begin
            r_q             <= mul_product[WIDTH-1:0];
            flags_q[FLAG_N] <= mul_product[MSB];
            flags_q[FLAG_Z] <= (mul_product[WIDTH-1:0] == '0);
            flags_q[FLAG_C] <= |mul_product[2*WIDTH-1:WIDTH];
            flags_q[FLAG_V] <= 1'b0;
            err_q           <= 1'b0;
            state           <= ST_HOLD;
            out_valid_q     <= 1'b1;
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) || (state == ST_HOLD && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;
  assign bus.ALUFlags  = flags_q;
  assign bus.err       = err_q;

endmodule
